// File: rtl/delta_ram_fifo_ctrl_if.sv
// Producer/consumer handshake bundle for the delta RAM FIFO controller.
//   master : producer/consumer side (drives wr_valid, wr_data, rd_ready)
//   slave  : controller side (drives wr_ready, rd_valid, rd_data)
interface delta_ram_fifo_ctrl_if #(
    parameter int SRAM_WIDTH = 28
);
    logic                  wr_valid;
    logic                  wr_ready;
    logic [SRAM_WIDTH-1:0] wr_data;
    logic                  rd_valid;
    logic                  rd_ready;
    logic [SRAM_WIDTH-1:0] rd_data;

    modport master (
        output wr_valid, wr_data, rd_ready,
        input  wr_ready, rd_valid, rd_data
    );

    modport slave (
        input  wr_valid, wr_data, rd_ready,
        output wr_ready, rd_valid, rd_data
    );
endinterface

// File: rtl/delta_ram_fifo_ctrl.sv
// Streaming FIFO controller on top of the single-port delta RAM.
// Arbitrates the one RAM port between producer writes and prefetch reads
// (round-robin on conflict) and keeps a 2-entry skid buffer so the consumer
// sees a registered stream.
//   clk, rst      : clock, synchronous active-high reset
//   bus (slave)   : wr_valid/wr_ready/wr_data, rd_valid/rd_ready/rd_data
//   level         : words held (RAM + in-flight read + skid)
//   ram_addr_w/r  : RAM write/read pointers
//   ram_write_en  : RAM write strobe
//   ram_read_en   : RAM read strobe (data returns next cycle)
//   ram_data_in   : write data to RAM (= wr_data)
//   ram_data_out  : registered RAM read data
module delta_ram_fifo_ctrl #(
    parameter int SRAM_DEPTH_BIT = 6,
    parameter int SRAM_DEPTH     = 2**SRAM_DEPTH_BIT,
    parameter int SRAM_WIDTH     = 28
) (
    input  logic                      clk,
    input  logic                      rst,
    delta_ram_fifo_ctrl_if.slave      bus,
    output logic [SRAM_DEPTH_BIT+1:0] level,
    output logic [SRAM_DEPTH_BIT-1:0] ram_addr_w,
    output logic [SRAM_DEPTH_BIT-1:0] ram_addr_r,
    output logic                      ram_write_en,
    output logic                      ram_read_en,
    output logic [SRAM_WIDTH-1:0]     ram_data_in,
    input  logic [SRAM_WIDTH-1:0]     ram_data_out
);
    typedef enum logic {GRANT_WR = 1'b0, GRANT_RD = 1'b1} grant_e;

    localparam logic [SRAM_DEPTH_BIT:0]   MEM_FULL = (SRAM_DEPTH_BIT+1)'(SRAM_DEPTH);
    localparam logic [SRAM_DEPTH_BIT:0]   CNT_ONE  = (SRAM_DEPTH_BIT+1)'(1);
    localparam logic [SRAM_DEPTH_BIT-1:0] PTR_ONE  = SRAM_DEPTH_BIT'(1);

    logic [SRAM_DEPTH_BIT-1:0] wr_ptr;
    logic [SRAM_DEPTH_BIT-1:0] rd_ptr;
    logic [SRAM_DEPTH_BIT:0]   mem_cnt;
    logic                      inflight;
    logic [SRAM_WIDTH-1:0]     skid [2];
    logic [1:0]                out_occ;
    grant_e                    last_grant;

    logic       wr_elig;
    logic       rd_elig;
    logic       pop;
    logic       do_write;
    logic       do_read;
    logic       conflict;
    logic [1:0] occ_after_pop;

    always_comb begin
        pop           = !rst && (out_occ != 2'd0) && bus.rd_ready;
        occ_after_pop = out_occ - {1'b0, pop};
        wr_elig       = mem_cnt < MEM_FULL;
        // A read issued now lands in the skid one cycle later, after any
        // word already in flight, so both must fit in the freed slots.
        rd_elig       = (mem_cnt != '0) &&
                        (({1'b0, occ_after_pop} + {2'b00, inflight}) < 3'd2);
        bus.wr_ready  = !rst && wr_elig && !(rd_elig && last_grant == GRANT_WR);
        do_write      = bus.wr_valid && bus.wr_ready;
        do_read       = !rst && rd_elig && !do_write;
        conflict      = !rst && wr_elig && rd_elig && bus.wr_valid;
    end

    assign bus.rd_valid = !rst && (out_occ != 2'd0);
    assign bus.rd_data  = skid[0];
    assign ram_addr_w   = wr_ptr;
    assign ram_addr_r   = rd_ptr;
    assign ram_write_en = do_write;
    assign ram_read_en  = do_read;
    assign ram_data_in  = bus.wr_data;
    assign level        = (SRAM_DEPTH_BIT+2)'(mem_cnt) +
                          (SRAM_DEPTH_BIT+2)'(inflight) +
                          (SRAM_DEPTH_BIT+2)'(out_occ);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            mem_cnt    <= '0;
            inflight   <= 1'b0;
            out_occ    <= '0;
            last_grant <= GRANT_RD;
            skid[0]    <= '0;
            skid[1]    <= '0;
        end else begin
            if (do_write) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_read)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_write, do_read})
                2'b10:   mem_cnt <= mem_cnt + CNT_ONE;
                2'b01:   mem_cnt <= mem_cnt - CNT_ONE;
                default: ;
            endcase
            inflight <= do_read;
            if (conflict) last_grant <= do_read ? GRANT_RD : GRANT_WR;

            // ram_data_out is only meaningful the cycle after a read issue.
            case ({inflight, pop})
                2'b10: skid[out_occ[0]] <= ram_data_out;
                2'b01: skid[0] <= skid[1];
                2'b11: begin
                    if (out_occ == 2'd2) begin
                        skid[0] <= skid[1];
                        skid[1] <= ram_data_out;
                    end else begin
                        skid[0] <= ram_data_out;
                    end
                end
                default: ;
            endcase
            out_occ <= out_occ + {1'b0, inflight} - {1'b0, pop};
        end
    end
endmodule

// File: doc/delta_ram_fifo_ctrl.md
# delta_ram_fifo_ctrl

Sequencing controller that turns the single-port delta RAM (shared address bus, one access per cycle, 1-cycle registered read) into a streaming FIFO with valid/ready on both sides. It sits between the delta producer (writes) and the delta consumer (reads). It arbitrates the single port between pending writes and prefetch reads, and holds a 2-entry output skid buffer so the consumer sees a registered stream.

## Interface
- SRAM_DEPTH_BIT, 6, RAM address width
- SRAM_DEPTH, 2**SRAM_DEPTH_BIT, RAM entries
- SRAM_WIDTH, 28, data width
- clk  in  1  single clock; all state updates on posedge
- rst  in  1  reset, synchronous and active-high
- wr_valid  in  1  producer has a word
- wr_ready  out  1  controller accepts the word this cycle
- wr_data  in  SRAM_WIDTH  producer word
- rd_valid  out  1  head word available
- rd_ready  in  1  consumer takes head word
- rd_data  out  SRAM_WIDTH  head word
- level  out  SRAM_DEPTH_BIT+2  total words held (RAM + in-flight + skid)
- ram_addr_w  out  SRAM_DEPTH_BIT  write pointer to RAM wrapper
- ram_addr_r  out  SRAM_DEPTH_BIT  read pointer to RAM wrapper
- ram_write_en  out  1  RAM write strobe
- ram_read_en  out  1  RAM read strobe
- ram_data_in  out  SRAM_WIDTH  equals wr_data
- ram_data_out  in  SRAM_WIDTH  RAM read data, valid the cycle after ram_read_en

## Operation
- State: wr_ptr, rd_ptr (SRAM_DEPTH_BIT, wrap modulo SRAM_DEPTH), mem_cnt (0..SRAM_DEPTH), inflight (1 bit), skid[0..1] with out_occ (0..2), last_grant (0=write, 1=read).
- Write eligible: mem_cnt < SRAM_DEPTH.
- Read eligible: mem_cnt > 0, and out_occ + inflight < 2 after this cycle's pop (a pop in the same cycle frees a slot).
- Arbitration:
  - Only one eligible side wins.
  - Both eligible and wr_valid=1: the side opposite last_grant wins (round-robin).
  - last_grant updates only on a conflict cycle.
- wr_ready = write eligible and not (read eligible and last_grant=0). It is combinational and does not depend on wr_valid.
- Write accept (wr_valid & wr_ready):
  - ram_write_en=1, ram_addr_w=wr_ptr.
  - wr_ptr++, mem_cnt++.
- Read issue:
  - ram_read_en=1, ram_addr_r=rd_ptr.
  - rd_ptr++, mem_cnt--, inflight set for next cycle.
- Hard invariant: ram_read_en and ram_write_en are never both 1.
- Capture: in a cycle with inflight=1, ram_data_out is appended to the skid tail. This is the only cycle ram_data_out is sampled.
- Pop: rd_valid & rd_ready removes skid[0] and shifts skid[1] down. Simultaneous capture and pop keeps out_occ unchanged; order is preserved.
- rd_valid = out_occ > 0. rd_data = skid[0].
- level = mem_cnt + inflight + out_occ. Maximum is SRAM_DEPTH+2.

## Timing
- Reset values: all pointers and counters 0, inflight=0, out_occ=0, last_grant=1 (write wins the first conflict).
- Output values during and after reset: rd_valid=0, wr_ready=0 while rst=1, ram_write_en=0, ram_read_en=0, level=0.
- rst asserted mid-operation: all contents are discarded in the next cycle. Any RAM data returned after reset is ignored.
- Write-to-read latency (empty FIFO, rd_ready=1, no contention):
  - Write accepted cycle t.
  - Read issued t+1.
  - Data captured t+2.
  - rd_valid=1 at t+3.
- Sustained throughput: 1 word every 2 cycles when both sides are active (single port). Reads run at 1/cycle when no writes are pending.
- Full (mem_cnt=SRAM_DEPTH): wr_ready=0 regardless of reads. Writes resume the cycle after a read issue decrements mem_cnt.
- Empty (mem_cnt=0): no read issue. An accepted write is not bypassed to the read side.
- Pointer wrap: SRAM_DEPTH-1 → 0 with no bubble.
- ram_* strobes and addresses are combinational from the current state and wr_valid/rd_ready. The RAM samples them at the next posedge.

## Test plan
- Reset then single write 0x0000ABC at cycle t, rd_ready=1 → ram_write_en at t (addr 0), ram_read_en at t+1 (addr 0), rd_valid and rd_data=0x0000ABC at t+3, level back to 0 after the pop.
- Fill with rd_ready=0: write 66 words with DEPTH_BIT=6.
  - level reaches 66: 64 in RAM + 2 in skid.
  - wr_ready=0 from that point.
  - No further ram_read_en while skid is full.
- Continuous wr_valid=1 and rd_ready=1 for 200 cycles, incrementing data → grants alternate W/R after the first conflict (write first), ram_read_en & ram_write_en never both 1, output sequence strictly incrementing, pointers wrap through 63→0 intact.
- Consumer backpressure toggling rd_ready every other cycle with 10 queued words → no loss or duplication. Simultaneous capture+pop keeps out_occ constant.
- Assert rst for one cycle while 5 words are queued and inflight=1 → next cycle level=0, rd_valid=0, and the stale ram_data_out is not captured.
- Full boundary: at mem_cnt=64 with a read issued in cycle t → wr_ready=1 at t+1, and the write lands at the freed wrap address.
